// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit direction counter
// encoding and its saturating update rule.
package bp_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t SNT = 2'b00;
  localparam bht_ctr_t WNT = 2'b01;
  localparam bht_ctr_t WT  = 2'b10;
  localparam bht_ctr_t ST  = 2'b11;

  function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    if (taken) begin
      res = (ctr == ST) ? ST : ctr + 2'd1;
    end else begin
      res = (ctr == SNT) ? SNT : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Statistics counter: increments on inc_i, sticks at all-ones, synchronous
// active-low reset to zero.
module bp_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency Fetch lookup,
// Execute-stage mispredict detection/redirect, table update and statistics.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             ResetN,
  input  logic [XLEN-1:0]  PCF,
  output logic             PredTakenF,
  output logic [XLEN-1:0]  PredTargetF,
  input  logic             BranchE,
  input  logic             NeedBranchE,
  input  logic             StallE,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [XLEN-1:0]  PCPlus4E,
  input  logic             PredTakenE,
  input  logic [XLEN-1:0]  PredTargetE,
  output logic             RedirectE,
  output logic [XLEN-1:0]  RedirectPCE,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MispredCnt
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  bht_ctr_t           ctr_q [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e, mis, upd;

  logic             wr_en;
  logic [TAG_W-1:0] tag_d;
  logic [XLEN-1:0]  tgt_d;
  bht_ctr_t         ctr_d;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[XLEN-1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[XLEN-1:IDX_W+2];

  // Fetch read sees pre-update contents; no bypass from the Execute write.
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredTakenF  = ResetN && hit_f && ctr_q[idx_f][1];
  assign PredTargetF = (ResetN && hit_f) ? tgt_q[idx_f] : '0;

  assign mis = BranchE && ((NeedBranchE != PredTakenE) ||
                           (NeedBranchE && PredTakenE && (PredTargetE != PCTargetE)));

  assign RedirectE   = ResetN && mis;
  assign FlushD      = ResetN && mis;
  assign FlushE      = ResetN && mis;
  assign RedirectPCE = !ResetN ? '0 : (NeedBranchE ? PCTargetE : PCPlus4E);

  assign upd   = ResetN && BranchE && !StallE;
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  always_comb begin
    wr_en = 1'b0;
    tag_d = tag_q[idx_e];
    tgt_d = tgt_q[idx_e];
    ctr_d = ctr_q[idx_e];
    if (upd) begin
      if (hit_e) begin
        wr_en = 1'b1;
        ctr_d = sat_update(ctr_q[idx_e], NeedBranchE);
        if (NeedBranchE) begin
          tgt_d = PCTargetE;
        end
      end else if (NeedBranchE) begin
        // Taken miss allocates or replaces, starting weakly taken.
        wr_en = 1'b1;
        tag_d = tag_e;
        tgt_d = PCTargetE;
        ctr_d = WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!ResetN) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= WNT;
      end
    end else if (wr_en) begin
      valid_q[idx_e] <= 1'b1;
      tag_q[idx_e]   <= tag_d;
      tgt_q[idx_e]   <= tgt_d;
      ctr_q[idx_e]   <= ctr_d;
    end
  end

  bp_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk_i  (clk),
    .rst_ni (ResetN),
    .inc_i  (upd),
    .cnt_o  (BranchCnt)
  );

  bp_sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk_i  (clk),
    .rst_ni (ResetN),
    .inc_i  (upd && mis),
    .cnt_o  (MispredCnt)
  );

endmodule
